// File: rtl/cnn_pkg.sv
// Shared width derivation, sign/zero extension and element packing helpers for the
// convolution kernel engine.
package cnn_pkg;

    function automatic int unsigned m_bw(input int unsigned i_f_bw, input int unsigned w_bw);
        return i_f_bw + w_bw;
    endfunction

    function automatic int unsigned ak_bw(input int unsigned mbw, input int unsigned n_elem);
        return mbw + $clog2(n_elem);
    endfunction

    function automatic int unsigned aci_bw(input int unsigned akbw, input int unsigned ci);
        return akbw + $clog2(ci);
    endfunction

    function automatic int unsigned o_f_bw(input int unsigned acibw);
        return acibw + 1;
    endfunction

    // LSB position of element k in a flat KX*KY vector of bw-wide elements.
    function automatic int unsigned elem_lsb(input int unsigned k, input int unsigned bw);
        return k * bw;
    endfunction

    // Extends the low w bits of v to 64 bits; callers size-cast the result down.
    function automatic logic [63:0] ext(input logic [63:0] v, input int unsigned w,
                                        input bit sgn);
        logic [63:0] mask;
        logic        sign;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sign = sgn && (((v >> (w - 1)) & 64'd1) != 64'd0);
        return (v & mask) | (sign ? ~mask : 64'd0);
    endfunction

endpackage

// File: rtl/cnn_adder_tree.sv
// Registered reduction of N operands; each operand is extended to W_OUT before summing
// so the sum cannot overflow.
module cnn_adder_tree
    import cnn_pkg::*;
#(
    parameter int unsigned N           = 9,
    parameter int unsigned W_IN        = 16,
    parameter int unsigned W_OUT       = 20,
    parameter bit          SIGNED_MODE = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_en,
    input  logic                i_clr,
    input  logic                i_valid,
    input  logic [N*W_IN-1:0]   i_operands,
    output logic                o_valid,
    output logic [W_OUT-1:0]    o_sum
);

    logic             valid_d, valid_q;
    logic [W_OUT-1:0] sum_d, sum_q;

    always_comb begin
        valid_d = valid_q;
        sum_d   = sum_q;
        if (i_clr) begin
            valid_d = 1'b0;
        end else if (i_en) begin
            valid_d = i_valid;
            sum_d   = '0;
            for (int unsigned k = 0; k < N; k++) begin
                sum_d = sum_d + W_OUT'(ext(64'(i_operands[elem_lsb(k, W_IN) +: W_IN]),
                                           W_IN, SIGNED_MODE));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
        end
    end

    assign o_valid = valid_q;
    assign o_sum   = sum_q;

endmodule

// File: rtl/cnn_kernel_ci_acc.sv
// Convolution kernel engine: multiply, adder-tree reduce, accumulate over CI channels, add
// bias. Define CNN_KERNEL_RELU_EN to clamp negative signed results to zero.
module cnn_kernel_ci_acc
    import cnn_pkg::*;
#(
    parameter int unsigned CI          = 3,
    parameter int unsigned KX          = 3,
    parameter int unsigned KY          = 3,
    parameter int unsigned I_F_BW      = 8,
    parameter int unsigned W_BW        = 8,
    parameter int unsigned B_BW        = 8,
    parameter bit          SIGNED_MODE = 1'b0,
    localparam int unsigned N_ELEM     = KX * KY,
    localparam int unsigned M_BW       = m_bw(I_F_BW, W_BW),
    localparam int unsigned AK_BW      = ak_bw(M_BW, N_ELEM),
    localparam int unsigned ACI_BW     = aci_bw(AK_BW, CI),
    localparam int unsigned O_F_BW     = o_f_bw(ACI_BW)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_soft_reset,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [N_ELEM*I_F_BW-1:0] i_in_fmap,
    input  logic [N_ELEM*W_BW-1:0]   i_cnn_weight,
    input  logic [B_BW-1:0]          i_cnn_bias,
    output logic                     o_ot_valid,
    input  logic                     i_ot_ready,
    output logic [O_F_BW-1:0]        o_ot_acc
);

    localparam int unsigned CNT_W = (CI > 1) ? $clog2(CI) : 1;

    logic                     en;
    logic                     valid1_d, valid1_q;
    logic [N_ELEM*M_BW-1:0]   mul_d, mul_q;
    logic [B_BW-1:0]          bias1_d, bias1_q, bias2_d, bias2_q;
    logic                     s2_valid;
    logic [AK_BW-1:0]         s2_sum;
    logic [CNT_W-1:0]         ci_cnt_d, ci_cnt_q;
    logic [ACI_BW-1:0]        acc_d, acc_q, acc_base, acc_sum;
    logic                     ot_valid_d, ot_valid_q;
    logic [O_F_BW-1:0]        ot_acc_d, ot_acc_q, result;
    logic                     last, advance;

    assign en         = !ot_valid_q || i_ot_ready;
    assign o_in_ready = en;

    // Operands are extended to M_BW first; the low M_BW bits of the product are then
    // correct for both signed and unsigned modes.
    always_comb begin
        valid1_d = valid1_q;
        mul_d    = mul_q;
        bias1_d  = bias1_q;
        bias2_d  = bias2_q;
        if (i_soft_reset) begin
            valid1_d = 1'b0;
        end else if (en) begin
            valid1_d = i_in_valid;
            bias1_d  = i_cnn_bias;
            bias2_d  = bias1_q;
            for (int unsigned k = 0; k < N_ELEM; k++) begin
                mul_d[elem_lsb(k, M_BW) +: M_BW] =
                    M_BW'(ext(64'(i_in_fmap[elem_lsb(k, I_F_BW) +: I_F_BW]), I_F_BW,
                              SIGNED_MODE)) *
                    M_BW'(ext(64'(i_cnn_weight[elem_lsb(k, W_BW) +: W_BW]), W_BW,
                              SIGNED_MODE));
            end
        end
    end

    cnn_adder_tree #(
        .N           (N_ELEM),
        .W_IN        (M_BW),
        .W_OUT       (AK_BW),
        .SIGNED_MODE (SIGNED_MODE)
    ) u_adder_tree (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (en),
        .i_clr      (i_soft_reset),
        .i_valid    (valid1_q),
        .i_operands (mul_q),
        .o_valid    (s2_valid),
        .o_sum      (s2_sum)
    );

    assign last    = (ci_cnt_q == CNT_W'(CI - 1));
    assign advance = en && s2_valid && !i_soft_reset;

    always_comb begin
        // Channel 0 starts a fresh group, which also covers CI == 1.
        acc_base = (ci_cnt_q == '0) ? '0 : acc_q;
        acc_sum  = acc_base + ACI_BW'(ext(64'(s2_sum), AK_BW, SIGNED_MODE));
        result   = O_F_BW'(ext(64'(acc_sum), ACI_BW, SIGNED_MODE)) +
                   O_F_BW'(ext(64'(bias2_q), B_BW, SIGNED_MODE));
`ifdef CNN_KERNEL_RELU_EN
        if (SIGNED_MODE && result[O_F_BW-1]) begin
            result = '0;
        end
`endif
    end

    always_comb begin
        ci_cnt_d   = ci_cnt_q;
        acc_d      = acc_q;
        ot_valid_d = ot_valid_q;
        ot_acc_d   = ot_acc_q;
        if (i_soft_reset) begin
            ci_cnt_d   = '0;
            ot_valid_d = 1'b0;
        end else if (en) begin
            ot_valid_d = s2_valid && last;
            if (advance) begin
                acc_d    = acc_sum;
                ci_cnt_d = last ? '0 : ci_cnt_q + 1'b1;
                if (last) begin
                    ot_acc_d = result;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid1_q   <= 1'b0;
            mul_q      <= '0;
            bias1_q    <= '0;
            bias2_q    <= '0;
            ci_cnt_q   <= '0;
            acc_q      <= '0;
            ot_valid_q <= 1'b0;
            ot_acc_q   <= '0;
        end else begin
            valid1_q   <= valid1_d;
            mul_q      <= mul_d;
            bias1_q    <= bias1_d;
            bias2_q    <= bias2_d;
            ci_cnt_q   <= ci_cnt_d;
            acc_q      <= acc_d;
            ot_valid_q <= ot_valid_d;
            ot_acc_q   <= ot_acc_d;
        end
    end

    assign o_ot_valid = ot_valid_q;
    assign o_ot_acc   = ot_acc_q;

endmodule

// File: tb/tb_cnn_kernel_ci_acc.sv
// Self-checking bench: unsigned and signed engines share one stimulus stream and are
// compared against an arithmetic model of window dot products summed over CI channels.
module tb_cnn_kernel_ci_acc;

    localparam int CI = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_soft_reset = 1'b0;
    logic        i_in_valid = 1'b0;
    logic [71:0] i_in_fmap = '0;
    logic [71:0] i_cnn_weight = '0;
    logic [7:0]  i_cnn_bias = '0;
    logic        i_ot_ready = 1'b1;
    logic        rdy_u, rdy_s, ov_u, ov_s;
    logic [22:0] acc_u, acc_s;

    int checks = 0;
    int errors = 0;

    logic [22:0] got_u[$], got_s[$], exp_u[$], exp_s[$];
    int          mcnt = 0;
    longint      macc_u = 0, macc_s = 0;

    always #5 clk = ~clk;

    cnn_kernel_ci_acc #(
        .CI(3), .KX(3), .KY(3), .I_F_BW(8), .W_BW(8), .B_BW(8), .SIGNED_MODE(1'b0)
    ) dut_u (
        .clk(clk), .reset_n(reset_n), .i_soft_reset(i_soft_reset), .i_in_valid(i_in_valid),
        .o_in_ready(rdy_u), .i_in_fmap(i_in_fmap), .i_cnn_weight(i_cnn_weight),
        .i_cnn_bias(i_cnn_bias), .o_ot_valid(ov_u), .i_ot_ready(i_ot_ready), .o_ot_acc(acc_u)
    );

    cnn_kernel_ci_acc #(
        .CI(3), .KX(3), .KY(3), .I_F_BW(8), .W_BW(8), .B_BW(8), .SIGNED_MODE(1'b1)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .i_soft_reset(i_soft_reset), .i_in_valid(i_in_valid),
        .o_in_ready(rdy_s), .i_in_fmap(i_in_fmap), .i_cnn_weight(i_cnn_weight),
        .i_cnn_bias(i_cnn_bias), .o_ot_valid(ov_s), .i_ot_ready(i_ot_ready), .o_ot_acc(acc_s)
    );

    function automatic longint ksum(input logic [71:0] f, input logic [71:0] w, input bit sgn);
        longint s;
        logic [7:0] a, b;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            a = f[k*8 +: 8];
            b = w[k*8 +: 8];
            if (sgn) s += longint'($signed(a)) * longint'($signed(b));
            else     s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    function automatic logic [71:0] rep(input logic [7:0] v);
        return {9{v}};
    endfunction

    function automatic logic [71:0] rand72();
        logic [71:0] r;
        r[31:0]  = $urandom();
        r[63:32] = $urandom();
        r[71:64] = 8'($urandom());
        return r;
    endfunction

    // Model and output collector, sampled mid-cycle.
    initial begin
        longint r;
        forever begin
            @(negedge clk);
            if (!reset_n || i_soft_reset) begin
                mcnt = 0; macc_u = 0; macc_s = 0;
            end else begin
                if (i_in_valid && rdy_u) begin
                    macc_u += ksum(i_in_fmap, i_cnn_weight, 1'b0);
                    macc_s += ksum(i_in_fmap, i_cnn_weight, 1'b1);
                    mcnt++;
                    if (mcnt == CI) begin
                        exp_u.push_back(23'(macc_u + longint'(i_cnn_bias)));
                        r = macc_s + longint'($signed(i_cnn_bias));
`ifdef CNN_KERNEL_RELU_EN
                        if (r < 0) r = 0;
`endif
                        exp_s.push_back(23'(r));
                        mcnt = 0; macc_u = 0; macc_s = 0;
                    end
                end
                if (ov_u && i_ot_ready) got_u.push_back(acc_u);
                if (ov_s && i_ot_ready) got_s.push_back(acc_s);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        got_u.delete(); got_s.delete(); exp_u.delete(); exp_s.delete();
    endtask

    task automatic send(input logic [71:0] f, input logic [71:0] w, input logic [7:0] b);
        int n;
        n = 0;
        i_in_fmap = f; i_cnn_weight = w; i_cnn_bias = b; i_in_valid = 1'b1;
        @(negedge clk);
        while (!rdy_u && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout got ready=%0b want 1", rdy_u);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        i_in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks += 4;
        if (ov_u !== 1'b0) begin errors++; $display("FAIL rst_valid_u got %b want 0", ov_u); end
        if (acc_u !== 23'd0) begin errors++; $display("FAIL rst_acc_u got %0d want 0", acc_u); end
        if (ov_s !== 1'b0) begin errors++; $display("FAIL rst_valid_s got %b want 0", ov_s); end
        if (acc_s !== 23'd0) begin errors++; $display("FAIL rst_acc_s got %0d want 0", acc_s); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (rdy_u !== 1'b1) begin errors++; $display("FAIL rst_ready_u got %b want 1", rdy_u); end
        if (rdy_s !== 1'b1) begin errors++; $display("FAIL rst_ready_s got %b want 1", rdy_s); end
    endtask

    task automatic test_back_to_back();
        logic [22:0] v;
        clear_q();
        repeat (3) send(rep(8'd1), rep(8'd2), 8'd5);
        i_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ov_u !== 1'b0) begin errors++; $display("FAIL lat_t1 got %b want 0", ov_u); end
        @(negedge clk);
        checks++;
        if (ov_u !== 1'b0) begin errors++; $display("FAIL lat_t2 got %b want 0", ov_u); end
        @(negedge clk);
        checks += 2;
        if (ov_u !== 1'b1) begin errors++; $display("FAIL lat_t3 got %b want 1", ov_u); end
        if (acc_u !== 23'd59) begin errors++; $display("FAIL lat_acc got %0d want 59", acc_u); end
        idle(5);
        checks += 3;
        if (got_u.size() != 1) begin
            errors++; $display("FAIL b2b_count got %0d want 1", got_u.size());
        end
        v = (got_s.size() > 0) ? got_s[0] : 'x;
        if (v !== 23'd59) begin errors++; $display("FAIL b2b_signed got %0d want 59", v); end
        v = (exp_u.size() > 0) ? exp_u[0] : 'x;
        if (acc_u !== v) begin errors++; $display("FAIL b2b_model got %0d want %0d", acc_u, v); end
    endtask

    task automatic test_group(input string name, input logic [7:0] f, input logic [7:0] w,
                              input logic [7:0] b, input logic [22:0] want_u,
                              input logic [22:0] want_s);
        logic [22:0] v;
        clear_q();
        repeat (3) send(rep(f), rep(w), b);
        idle(6);
        checks += 4;
        v = (got_u.size() == 1) ? got_u[0] : 'x;
        if (v !== want_u) begin errors++; $display("FAIL %s_u got %0d want %0d", name, v, want_u); end
        v = (got_s.size() == 1) ? got_s[0] : 'x;
        if (v !== want_s) begin errors++; $display("FAIL %s_s got %0d want %0d", name, v, want_s); end
        v = (exp_u.size() == 1) ? exp_u[0] : 'x;
        if (acc_u !== v) begin errors++; $display("FAIL %s_model_u got %0d want %0d", name, acc_u, v); end
        v = (exp_s.size() == 1) ? exp_s[0] : 'x;
        if (acc_s !== v) begin errors++; $display("FAIL %s_model_s got %0d want %0d", name, acc_s, v); end
    endtask

    task automatic test_backpressure();
        int n;
        logic [22:0] v;
        clear_q();
        i_ot_ready = 1'b0;
        fork
            begin
                repeat (6) send(rand72(), rand72(), 8'($urandom()));
                i_in_valid = 1'b0;
            end
            begin
                n = 0;
                @(negedge clk);
                while (!ov_u && n < 100) begin @(negedge clk); n++; end
                repeat (4) begin
                    @(negedge clk);
                    checks += 3;
                    v = (exp_u.size() > 0) ? exp_u[0] : 'x;
                    if (rdy_u !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", rdy_u); end
                    if (acc_u !== v) begin errors++; $display("FAIL bp_hold_u got %0d want %0d", acc_u, v); end
                    v = (exp_s.size() > 0) ? exp_s[0] : 'x;
                    if (acc_s !== v) begin errors++; $display("FAIL bp_hold_s got %0d want %0d", acc_s, v); end
                end
                @(posedge clk); #1;
                i_ot_ready = 1'b1;
            end
        join
        idle(10);
        checks += 2;
        if (got_u.size() != 2 || exp_u.size() != 2) begin
            errors++; $display("FAIL bp_count got %0d want 2", got_u.size());
        end
        if (got_s.size() != 2) begin errors++; $display("FAIL bp_count_s got %0d want 2", got_s.size()); end
        for (int i = 0; i < got_u.size() && i < exp_u.size(); i++) begin
            checks++;
            if (got_u[i] !== exp_u[i]) begin
                errors++; $display("FAIL bp_val_u[%0d] got %0d want %0d", i, got_u[i], exp_u[i]);
            end
        end
        for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
            checks++;
            if (got_s[i] !== exp_s[i]) begin
                errors++; $display("FAIL bp_val_s[%0d] got %0d want %0d", i, got_s[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_soft_reset();
        logic [22:0] v;
        clear_q();
        repeat (2) send(rand72(), rand72(), 8'($urandom()));
        idle(5);
        i_soft_reset = 1'b1;
        @(posedge clk); #1;
        i_soft_reset = 1'b0;
        repeat (3) send(rep(8'd1), rep(8'd1), 8'd0);
        idle(6);
        checks += 3;
        if (got_u.size() != 1) begin errors++; $display("FAIL sr_count got %0d want 1", got_u.size()); end
        v = (got_u.size() > 0) ? got_u[0] : 'x;
        if (v !== 23'd27) begin errors++; $display("FAIL sr_val_u got %0d want 27", v); end
        v = (got_s.size() > 0) ? got_s[0] : 'x;
        if (v !== 23'd27) begin errors++; $display("FAIL sr_val_s got %0d want 27", v); end
    endtask

    task automatic test_bubbles();
        clear_q();
        for (int i = 0; i < 6; i++) begin
            send(rep(8'd1), rep(8'd2), 8'd5);
            if (i == 3) idle(3);
        end
        idle(8);
        checks++;
        if (got_u.size() != 2) begin errors++; $display("FAIL bub_count got %0d want 2", got_u.size()); end
        for (int i = 0; i < got_u.size(); i++) begin
            checks++;
            if (got_u[i] !== 23'd59) begin errors++; $display("FAIL bub_val[%0d] got %0d want 59", i, got_u[i]); end
        end
    endtask

    task automatic test_random();
        bit stop;
        stop = 1'b0;
        clear_q();
        fork
            begin
                for (int i = 0; i < 42; i++) begin
                    send(rand72(), rand72(), 8'($urandom()));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                i_in_valid = 1'b0;
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1;
                    i_ot_ready = ($urandom_range(0, 2) != 0);
                end
                i_ot_ready = 1'b1;
            end
        join
        idle(10);
        checks += 2;
        if (got_u.size() != 14 || exp_u.size() != 14) begin
            errors++; $display("FAIL rnd_count_u got %0d want 14", got_u.size());
        end
        if (got_s.size() != 14) begin errors++; $display("FAIL rnd_count_s got %0d want 14", got_s.size()); end
        for (int i = 0; i < got_u.size() && i < exp_u.size(); i++) begin
            checks++;
            if (got_u[i] !== exp_u[i]) begin
                errors++; $display("FAIL rnd_u[%0d] got %0d want %0d", i, got_u[i], exp_u[i]);
            end
        end
        for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
            checks++;
            if (got_s[i] !== exp_s[i]) begin
                errors++; $display("FAIL rnd_s[%0d] got %0d want %0d", i, got_s[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [22:0] v;
        clear_q();
        i_ot_ready = 1'b0;
        // Third beat completes a held result; two more beats sit mid-group in the pipe.
        repeat (5) send(rep(8'd1), rep(8'd1), 8'd0);
        idle(3);
        checks++;
        if (acc_u !== 23'd27) begin errors++; $display("FAIL ar_pre got %0d want 27", acc_u); end
        #2;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (ov_u !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", ov_u); end
        if (acc_u !== 23'd0) begin errors++; $display("FAIL ar_acc_u got %0d want 0", acc_u); end
        if (acc_s !== 23'd0) begin errors++; $display("FAIL ar_acc_s got %0d want 0", acc_s); end
        if (rdy_u !== 1'b1) begin errors++; $display("FAIL ar_ready got %b want 1", rdy_u); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        i_ot_ready = 1'b1;
        clear_q();
        repeat (3) send(rep(8'd1), rep(8'd2), 8'd5);
        idle(6);
        checks += 2;
        if (got_u.size() != 1) begin errors++; $display("FAIL ar_count got %0d want 1", got_u.size()); end
        v = (got_u.size() > 0) ? got_u[0] : 'x;
        if (v !== 23'd59) begin errors++; $display("FAIL ar_val got %0d want 59", v); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
`ifdef CNN_KERNEL_RELU_EN
        test_group("signed", 8'hFF, 8'd3, 8'hFC, 23'd20907, 23'd0);
`else
        test_group("signed", 8'hFF, 8'd3, 8'hFC, 23'd20907, 23'h7FFFAB);
`endif
        test_group("max", 8'hFF, 8'hFF, 8'hFF, 23'd1755930, 23'd26);
        test_backpressure();
        test_soft_reset();
        test_bubbles();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
